// File: rtl/seq_sub_ctrl.sv
// Multi-cycle wide subtractor: one SLICE_W-bit slice per cycle, LSB first, with
// registered result and NZCV flags. Define SEQ_SUB_BIN_EN to add a borrow_in port.

module top_sub #(
  parameter int unsigned x = 4
) (
  input  logic [x-1:0] a,
  input  logic [x-1:0] b,
  input  logic         cin,
  output logic [x-1:0] r,
  output logic         cout,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v
);

  logic [x:0] diff;

  // Bit x of the widened difference is the borrow-out.
  assign diff = {1'b0, a} - {1'b0, b} - {{x{1'b0}}, cin};
  assign r    = diff[x-1:0];
  assign cout = diff[x];
  assign n    = diff[x-1];
  assign z    = (diff[x-1:0] == '0);
  assign c    = diff[x];
  assign v    = (a[x-1] != b[x-1]) && (a[x-1] != diff[x-1]);

endmodule

module seq_sub_ctrl #(
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned NSLICES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
`ifdef SEQ_SUB_BIN_EN
  input  logic                       borrow_in,
`endif
  input  logic [SLICE_W*NSLICES-1:0] a,
  input  logic [SLICE_W*NSLICES-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NSLICES-1:0] r,
  output logic                       flag_n,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic                       flag_v
);

  localparam int unsigned N     = SLICE_W * NSLICES;
  localparam int unsigned IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic [N-1:0]       shadow;
  logic [N-1:0]       shadow_next;
  logic [IDX_W-1:0]   idx;
  logic               borrow;
  logic               init_borrow;
  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_r;
  logic               slice_cout;

`ifdef SEQ_SUB_BIN_EN
  assign init_borrow = borrow_in;
`else
  assign init_borrow = 1'b0;
`endif

  assign accept  = (state == IDLE) && start;
  assign last    = (state == RUN) && (idx == IDX_LAST);
  assign slice_a = a_q[idx*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx*SLICE_W +: SLICE_W];

  top_sub #(.x(SLICE_W)) u_sub (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (borrow),
    .r    (slice_r),
    .cout (slice_cout),
    .n    (),
    .z    (),
    .c    (),
    .v    ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (idx == IDX_LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final slice is merged combinationally so r/flags load in one edge.
  always_comb begin
    shadow_next = shadow;
    shadow_next[idx*SLICE_W +: SLICE_W] = slice_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      r      <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      idx    <= '0;
      borrow <= init_borrow;
    end else if (state == RUN) begin
      shadow <= shadow_next;
      borrow <= slice_cout;
      idx    <= last ? '0 : idx + 1'b1;
      if (last) begin
        r      <= shadow_next;
        flag_n <= shadow_next[N-1];
        flag_z <= (shadow_next == '0);
        flag_c <= slice_cout;
        flag_v <= (a_q[N-1] != b_q[N-1]) && (a_q[N-1] != shadow_next[N-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_sub_ctrl.sv
// Directed bench for seq_sub_ctrl (SLICE_W=4, NSLICES=4) with a result scoreboard.
// Build with SEQ_SUB_BIN_EN defined to also exercise borrow_in.

module tb_seq_sub_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bin   = 1'b0;
  logic [15:0] op_a  = '0;
  logic [15:0] op_b  = '0;
  logic        busy, done, fn, fz, fc, fv;
  logic [15:0] r;

  typedef struct packed {
    logic [15:0] r;
    logic        n, z, c, v;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] held_r = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_sub_ctrl #(.SLICE_W(4), .NSLICES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SEQ_SUB_BIN_EN
    .borrow_in (bin),
`endif
    .a         (op_a),
    .b         (op_b),
    .busy      (busy),
    .done      (done),
    .r         (r),
    .flag_n    (fn),
    .flag_z    (fz),
    .flag_c    (fc),
    .flag_v    (fv)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] d;
    exp_t e;
    d   = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    e.r = d[15:0];
    e.c = d[16];
    e.n = d[15];
    e.z = (d[15:0] == 16'h0000);
    e.v = (x[15] != y[15]) && (x[15] != d[15]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_sb"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_nzcv"}, {fn, fz, fc, fv}, {e.n, e.z, e.c, e.v});
      held_r = e.r;
    end
  endtask

  task automatic wait_done(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk({tag, "_timeout"}, done, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y);
    int lat, bcnt;
    @(negedge clk);
    op_a = x; op_b = y; start = 1'b1;
    sb.push_back(model(x, y, bin));
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (i == 4) chk({tag, "_hold"}, r, held_r);
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_busy"}, bcnt, 5);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int t1, t2, cnt;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r", r, 16'h0000);
    chk("rst_flags", {fn, fz, fc, fv}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("c1", 16'h1234, 16'h0034);
    chk("c1_const", {r, fn, fz, fc, fv}, {16'h1200, 4'b0000});
    run_op("c2", 16'h0000, 16'h0001);
    chk("c2_const", {r, fn, fz, fc, fv}, {16'hFFFF, 4'b1010});
    run_op("c3a", 16'h8000, 16'h0001);
    chk("c3a_const", {r, fn, fz, fc, fv}, {16'h7FFF, 4'b0001});
    run_op("c3b", 16'h7FFF, 16'hFFFF);
    chk("c3b_const", {r, fn, fc, fv}, {16'h8000, 3'b111});
    run_op("c4", 16'h5A5A, 16'h5A5A);
    chk("c4_const", {r, fz, fc}, {16'h0000, 2'b10});

    // back-to-back with start held high
    @(negedge clk);
    op_a = 16'hC3A5; op_b = 16'h1F2E; start = 1'b1;
    sb.push_back(model(16'hC3A5, 16'h1F2E, bin));
    @(negedge clk);
    op_a = 16'h0F00; op_b = 16'h7001;
    sb.push_back(model(16'h0F00, 16'h7001, bin));
    wait_done("b2b1", t1);
    check_result("b2b1");
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", t2);
    check_result("b2b2");
    chk("b2b_spacing", t2 - t1, 6);

    // start pulsed mid-RUN with new operands is ignored
    @(negedge clk);
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; start = 1'b1;
    sb.push_back(model(16'h4321, 16'h1111, bin));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", t1);
    check_result("ign");
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    chk("ign_noqueue", cnt, 0);

    // reset asserted in RUN cycle 2 aborts the op
    op_a = 16'h1234; op_b = 16'h0034; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_r", r, 16'h0000);
    chk("abort_flags", {fn, fz, fc, fv}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    held_r = 16'h0000;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    chk("abort_nodone", cnt, 0);
    run_op("post_rst", 16'h1234, 16'h0034);
    chk("post_rst_const", r, 16'h1200);

`ifdef SEQ_SUB_BIN_EN
    bin = 1'b1;
    run_op("bin1", 16'h0010, 16'h0000);
    chk("bin1_const", {r, fc}, {16'h000F, 1'b0});
    run_op("bin2", 16'h0000, 16'h0000);
    chk("bin2_const", {r, fc}, {16'hFFFF, 1'b1});
    bin = 1'b0;
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
